ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Front-end fetch block: owns the fetch PC, issues single-outstanding instruction reads on the imem/ufp port, and buffers returned `{pc, inst}` pairs in a circular queue. Decode pulls entries from the queue head. Sits directly upstream of the decode stage and drives its `{pc, inst}` input and the `is_empty` / `dequeue` handshake. A redirect from the branch/jump path flushes the queue and any in-flight read.

## Interface
- `DEPTH`, 8 — queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h1ECE_B000 — fetch PC after reset.

- `clk`  in  1 — single clock; all state updates on the rising edge.
- `rst`  in  1 — reset; synchronous, active-high.
- `ufp_addr`  out  32 — read address; always equals the fetch PC register.
- `ufp_rmask`  out  4 — 4'hF while a request is outstanding, else 4'h0.
- `ufp_rdata`  in  32 — instruction word; valid only when `ufp_resp`=1.
- `ufp_resp`  in  1 — one-cycle read completion.
- `redirect`  in  1 — flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32 — new fetch PC; word aligned.
- `dequeue`  in  1 — pop the queue head; ignored when `is_empty`=1.
- `is_empty`  out  1 — queue holds no entries.
- `is_full`  out  1 — queue holds `DEPTH` entries.
- `dequeue_rdata`  out  64 — head entry `{pc[63:32], inst[31:0]}`; first-word fall-through.
- `count`  out  $clog2(DEPTH)+1 — number of valid entries.

## Operation
- Storage: `DEPTH` × 64-bit array. `head`/`tail` pointers are $clog2(DEPTH) bits and wrap naturally. `count` is tracked separately.
- FSM states:
  - IDLE: `rmask`=0.
  - BUSY: `rmask`=F; `addr` and `rmask` held stable until `ufp_resp`.
  - DISCARD: `rmask`=F on the stale address; the response is dropped.
- IDLE → BUSY when `!redirect && count < DEPTH`.
- BUSY with `ufp_resp` and no `redirect`:
  - enqueue `{pc, ufp_rdata}` at `tail`;
  - pc ← pc + 4 (mod 2^32);
  - go to BUSY if the post-update count < DEPTH, else IDLE.
- BUSY with `redirect`, no `ufp_resp` → DISCARD. pc ← `redirect_pc`; `ufp_addr` stays on the old address until the response arrives.
  - Requirement: the address output is driven from a separate request-address register that loads only when a request is issued.
  - `ufp_addr` reflects the fetch PC whenever `rmask`=0.
- BUSY with `redirect` and `ufp_resp` in the same cycle: data is dropped, no enqueue, pc ← `redirect_pc`, go to IDLE.
- DISCARD on `ufp_resp` → IDLE, no enqueue. A further redirect while in DISCARD only updates pc.
- `redirect` in any state:
  - `head`, `tail`, `count` ← 0 next cycle;
  - any enqueue or dequeue that cycle is suppressed.
- No overflow by construction: a request is issued only when count < DEPTH and at most one is outstanding.
- Dequeue while empty: no pointer or count change. Simultaneous enqueue and dequeue: count unchanged, both pointers advance.

## Timing
- Reset values:
  - state IDLE, pc = request address = `RESET_PC`;
  - `head` = `tail` = `count` = 0;
  - `ufp_rmask` = 0, `is_empty` = 1, `is_full` = 0;
  - `dequeue_rdata` content don't-care.
- First request (`rmask`=F, `addr`=`RESET_PC`) in the first cycle after `rst` deasserts.
- Reset asserted mid-request: the outstanding request is abandoned without waiting for `ufp_resp`. The memory side is reset by the same `rst`.
- Enqueue latency: data on the `ufp_resp` edge is visible on `dequeue_rdata` with `is_empty`=0 in the next cycle.
- Back-to-back: with the queue not filling, the next request is presented in the cycle after `ufp_resp`. Sustains one instruction per memory response.
- `is_empty`, `is_full`, `count` are registered-state derived; no combinational path from `dequeue` or `ufp_resp`.
- `dequeue_rdata` is a combinational read of `array[head]`.

## Test plan
- Reset, memory responds 1 cycle after every request, `dequeue`=0:
  - addresses 1ECE_B000, …_B004, … _B01C enqueued;
  - `is_full`=1, `count`=8, `rmask`=0 afterward;
  - `dequeue_rdata`={1ECE_B000, word0}.
- Continuous `dequeue` whenever `!is_empty`, memory latency 3 cycles: entries emerge in PC order with no duplicates or gaps across pointer wrap (≥ 20 instructions).
- `redirect`=1, `redirect_pc`=0x1ECE_C000 while BUSY, response 2 cycles later:
  - response dropped;
  - `count`=0 next cycle;
  - next request addr=0x1ECE_C000;
  - first dequeued pc=0x1ECE_C000.
- `redirect` coincident with `ufp_resp`: no enqueue, queue empty next cycle, next request at `redirect_pc` the following cycle.
- Full queue, one `dequeue`: `count` 8→7, new request at the next sequential pc. Its response with a simultaneous `dequeue` keeps `count`=7.
- `dequeue` while empty and `rst` mid-request: `count` stays 0; after reset the request restarts at `RESET_PC` and `rmask` returns to 0 during `rst`.

Source files
------------

// File: rtl/ifetch_queue.sv
// Front-end fetch: owns the fetch PC, keeps one imem read outstanding at a time and
// buffers returned {pc, inst} pairs in a circular queue drained by decode.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1ECE_B000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            ufp_addr,
  output logic [3:0]             ufp_rmask,
  input  logic [31:0]            ufp_rdata,
  input  logic                   ufp_resp,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   dequeue,
  output logic                   is_empty,
  output logic                   is_full,
  output logic [63:0]            dequeue_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      reqAddr_q, reqAddr_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      entries_q [DEPTH];
  logic             doEnq, doDeq;

  // A redirect wins over any push or pop in the same cycle and empties the queue.
  always_comb begin
    doEnq   = (state_q == BUSY) && ufp_resp && !redirect;
    doDeq   = dequeue && (count_q != '0) && !redirect;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doEnq) tail_d = tail_q + PTR_W'(1);
      if (doDeq) head_d = head_q + PTR_W'(1);
      if (doEnq && !doDeq) begin
        count_d = count_q + CNT_W'(1);
      end else if (!doEnq && doDeq) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // reqAddr_q only loads when a request is issued, so a redirect during an
  // outstanding read moves pc_q without disturbing the address on the bus.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    reqAddr_d = reqAddr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (count_q < FULL_CNT) begin
          state_d   = BUSY;
          reqAddr_d = pc_q;
        end
      end
      BUSY: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ufp_resp ? IDLE : DISCARD;
        end else if (ufp_resp) begin
          pc_d = pc_q + 32'd4;
          if (count_d < FULL_CNT) begin
            state_d   = BUSY;
            reqAddr_d = pc_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) pc_d = redirect_pc;
        if (ufp_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      reqAddr_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqAddr_q <= reqAddr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && doEnq) entries_q[tail_q] <= {pc_q, ufp_rdata};
  end

  assign ufp_rmask     = (state_q == IDLE) ? 4'h0 : 4'hF;
  assign ufp_addr      = (state_q == IDLE) ? pc_q : reqAddr_q;
  assign is_empty      = (count_q == '0);
  assign is_full       = (count_q == FULL_CNT);
  assign count         = count_q;
  assign dequeue_rdata = entries_q[head_q];

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed fill, drain, redirect and reset scenarios
// against a small instruction memory with programmable response latency.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h1ECE_B000;

  logic        clk;
  logic        rst;
  logic [31:0] ufp_addr;
  logic [3:0]  ufp_rmask;
  logic [31:0] ufp_rdata;
  logic        ufp_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dequeue;
  logic        is_empty;
  logic        is_full;
  logic [63:0] dequeue_rdata;
  logic [3:0]  count;

  int          memLat;
  int          waitCnt;
  logic [63:0] expQ[$];
  logic [63:0] monExp;
  int          totalCnt = 0;
  int          badCnt = 0;
  logic        seen;

  ifetch_queue #(.DEPTH(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dequeue(dequeue), .is_empty(is_empty), .is_full(is_full),
    .dequeue_rdata(dequeue_rdata), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return ~a ^ 32'h0000_5A5A;
  endfunction

  function automatic logic [63:0] entryOf(input logic [31:0] a);
    return {a, wordOf(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic deq, input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    dequeue     = deq;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic waitFull(input int maxCycles);
    for (int i = 0; i < maxCycles && !is_full; i++) @(negedge clk);
    checkOutput("fillWait", 64'(is_full), 64'd1);
  endtask

  task automatic waitResp(input int maxCycles);
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge clk);
      seen = ufp_resp;
    end
    checkOutput("respWait", 64'(seen), 64'd1);
  endtask

  task automatic drainExpected(input int maxCycles);
    for (int i = 0; i < maxCycles && expQ.size() > 0; i++) begin
      @(posedge clk);
      #1;
      dequeue = !is_empty && (expQ.size() > 0);
    end
    @(posedge clk);
    #1;
    dequeue = 1'b0;
    checkOutput("drainLeft", 64'(expQ.size()), 64'd0);
  endtask

  // Memory: answers the outstanding request memLat cycles after it first appears.
  initial begin
    ufp_resp  = 1'b0;
    ufp_rdata = '0;
    waitCnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ufp_resp) begin
        ufp_resp = 1'b0;
        waitCnt  = 0;
      end
      if (rst) begin
        waitCnt = 0;
      end else if (ufp_rmask == 4'hF) begin
        if (waitCnt == memLat) begin
          ufp_resp  = 1'b1;
          ufp_rdata = wordOf(ufp_addr);
        end else begin
          waitCnt++;
        end
      end
    end
  end

  // Monitor: every accepted pop must match the next expected entry in order.
  always @(negedge clk) begin
    if (!rst && dequeue && !is_empty) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        badCnt++;
        $display("[TB] FAIL popUnexpected: got %h, want no entry", dequeue_rdata);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("popEntry", dequeue_rdata, monExp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    dequeue     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    memLat      = 1;

    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rstRmask", 64'(ufp_rmask), 64'h0);
    checkOutput("rstEmpty", 64'(is_empty), 64'd1);
    checkOutput("rstFull", 64'(is_full), 64'd0);
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstAddr", 64'(ufp_addr), 64'(RESET_PC));

    // Fill from reset with a one-cycle memory.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("firstReqMask", 64'(ufp_rmask), 64'hF);
    checkOutput("firstReqAddr", 64'(ufp_addr), 64'h1ECE_B000);
    for (int i = 0; i < 8; i++) expQ.push_back(entryOf(32'h1ECE_B000 + 32'(4 * i)));
    waitFull(100);
    checkOutput("fillCount", 64'(count), 64'd8);
    checkOutput("fillRmask", 64'(ufp_rmask), 64'h0);
    checkOutput("fillHead", dequeue_rdata, {32'h1ECE_B000, wordOf(32'h1ECE_B000)});
    checkOutput("fillNextPc", 64'(ufp_addr), 64'h1ECE_B020);

    // Single pop from full restarts fetch; next response with a pop holds count.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("popCount7", 64'(count), 64'd7);
    checkOutput("popIdle", 64'(ufp_rmask), 64'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("refillMask", 64'(ufp_rmask), 64'hF);
    checkOutput("refillAddr", 64'(ufp_addr), 64'h1ECE_B020);
    expQ.push_back(entryOf(32'h1ECE_B020));
    expQ.push_back(entryOf(32'h1ECE_B024));
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("enqDeqCount", 64'(count), 64'd7);

    // Continuous draining with a slower memory, across pointer wrap.
    memLat = 3;
    for (int i = 0; i < 22; i++) expQ.push_back(entryOf(32'h1ECE_B028 + 32'(4 * i)));
    drainExpected(600);

    // Redirect while a request is outstanding: stale response is dropped.
    waitFull(200);
    applyStimulus(1'b0, 1'b1, 32'h1ECE_8000);
    expQ.delete();
    memLat = 2;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("idleRedirCount", 64'(count), 64'd0);
    checkOutput("idleRedirAddr", 64'(ufp_addr), 64'h1ECE_8000);
    applyStimulus(1'b0, 1'b1, 32'h1ECE_C000);
    @(negedge clk);
    checkOutput("busyReqAddr", 64'(ufp_addr), 64'h1ECE_8000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("discardCount", 64'(count), 64'd0);
    checkOutput("discardMask", 64'(ufp_rmask), 64'hF);
    checkOutput("discardAddr", 64'(ufp_addr), 64'h1ECE_8000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("droppedEmpty", 64'(is_empty), 64'd1);
    checkOutput("droppedAddr", 64'(ufp_addr), 64'h1ECE_C000);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redirReqMask", 64'(ufp_rmask), 64'hF);
    checkOutput("redirReqAddr", 64'(ufp_addr), 64'h1ECE_C000);
    expQ.push_back(entryOf(32'h1ECE_C000));
    drainExpected(50);

    // Redirect coincident with a response, with one entry already queued.
    waitResp(20);
    waitResp(20);
    checkOutput("preFlushCount", 64'(count), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h1ECE_E000;
    expQ.delete();
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("coinEmpty", 64'(is_empty), 64'd1);
    checkOutput("coinCount", 64'(count), 64'd0);
    checkOutput("coinMask", 64'(ufp_rmask), 64'h0);
    checkOutput("coinAddr", 64'(ufp_addr), 64'h1ECE_E000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("emptyDeqCount", 64'(count), 64'd0);
    checkOutput("coinReqMask", 64'(ufp_rmask), 64'hF);
    checkOutput("coinReqAddr", 64'(ufp_addr), 64'h1ECE_E000);

    // Reset in the middle of an outstanding request.
    @(posedge clk);
    #1;
    dequeue = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checkOutput("emptyDeqCount2", 64'(count), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("midRstMask", 64'(ufp_rmask), 64'h0);
    checkOutput("midRstAddr", 64'(ufp_addr), 64'(RESET_PC));
    checkOutput("midRstCount", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("restartMask", 64'(ufp_rmask), 64'hF);
    checkOutput("restartAddr", 64'(ufp_addr), 64'(RESET_PC));
    expQ.push_back(entryOf(32'h1ECE_B000));
    drainExpected(50);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
